// File: rtl/mash111_ncl_pkg.sv
// Shared types, constants and helpers for the MASH 1-1-1 noise-cancellation stage.
// Optional feature macro: NCL_DITHER_EN (LFSR dither source for the stage-1 LSB).
package mash111_ncl_pkg;

    // Cancellation output: 4-bit signed, spans -3..+4.
    localparam int unsigned Y_W = 4;
    typedef logic signed [Y_W-1:0] ncl_y_t;
    localparam int Y_MIN = -3;
    localparam int Y_MAX = 4;

    // Dither LFSR: x^15 + x^14 + 1, Fibonacci form.
    localparam int unsigned            LFSR_W    = 15;
    localparam logic [LFSR_W-1:0]      LFSR_TAPS = 15'h6000;
    localparam logic [LFSR_W-1:0]      LFSR_SEED = 15'h0001;

    // Clamp a signed value into [lo, hi].
    function automatic int sat_clamp(input int v, input int lo, input int hi);
        int r;
        r = v;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end
        return r;
    endfunction

    // One shift of the Fibonacci LFSR; feedback enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mash111_ncl_diff.sv
// Carry history, MASH 1-1-1 cancellation network and the registered correction y_r.
module mash111_ncl_diff
    import mash111_ncl_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en_i,
    input  logic   c1_i,
    input  logic   c2_i,
    input  logic   c3_i,
    output ncl_y_t y_r_o
);

    logic   r_c1_d1;
    logic   r_c1_d2;
    logic   r_c2_d1;
    logic   r_c2_d2;
    logic   r_c3_d1;
    logic   r_c3_d2;
    ncl_y_t r_y;
    ncl_y_t w_y;

    // y = c1[n-2] + (c2[n-1] - c2[n-2]) + (c3[n] - 2*c3[n-1] + c3[n-2]); modulo-16 math is exact here.
    always_comb begin
        w_y = ncl_y_t'({3'b000, r_c1_d2}
                     + {3'b000, r_c2_d1}
                     - {3'b000, r_c2_d2}
                     + {3'b000, c3_i}
                     - {2'b00, r_c3_d1, 1'b0}
                     + {3'b000, r_c3_d2});
    end

    // History shift and first pipeline stage; everything freezes while en_i is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c1_d1 <= 1'b0;
            r_c1_d2 <= 1'b0;
            r_c2_d1 <= 1'b0;
            r_c2_d2 <= 1'b0;
            r_c3_d1 <= 1'b0;
            r_c3_d2 <= 1'b0;
            r_y     <= '0;
        end else if (en_i) begin
            r_c1_d1 <= c1_i;
            r_c1_d2 <= r_c1_d1;
            r_c2_d1 <= c2_i;
            r_c2_d2 <= r_c2_d1;
            r_c3_d1 <= c3_i;
            r_c3_d2 <= r_c3_d1;
            r_y     <= w_y;
        end
    end

    assign y_r_o = r_y;

endmodule

// File: rtl/mash111_ncl.sv
// MASH 1-1-1 noise cancellation plus saturated divide-ratio register and integer-word load handshake.
// Optional feature macro: NCL_DITHER_EN (when undefined, dither_o is tied low).
module mash111_ncl
    import mash111_ncl_pkg::*;
#(
    parameter int unsigned INT_W   = 8,
    parameter int unsigned INT_RST = 32,
    parameter int unsigned DIV_MIN = 8,
    parameter int unsigned DIV_MAX = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             c1_i,
    input  logic             c2_i,
    input  logic             c3_i,
    input  logic [INT_W-1:0] int_i,
    input  logic             int_load_i,
    output logic             int_ack_o,
    output logic [INT_W-1:0] div_o,
    output logic             div_vld_o,
    output logic             sat_o,
    output logic             sat_sticky_o,
    output logic             dither_o
);

    // Two guard bits keep int + y exact over 0..2^INT_W-1 plus -3..+4.
    localparam int unsigned SUM_W = INT_W + 2;

    ncl_y_t                  w_y_r;
    logic [SUM_W-1:0]        w_sum_u;
    logic signed [SUM_W-1:0] w_sum;
    int                      w_sum_i;
    logic                    w_capture;
    logic                    w_clamp;

    logic [INT_W-1:0]        r_int_active;
    logic                    r_ack;
    logic [INT_W-1:0]        r_div;
    logic                    r_vld;
    logic                    r_sat;
    logic                    r_sticky;

    mash111_ncl_diff u_diff (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en_i),
        .c1_i  (c1_i),
        .c2_i  (c2_i),
        .c3_i  (c3_i),
        .y_r_o (w_y_r)
    );

    // Unclamped ratio and clamp detection; a pending ack blocks a fresh capture.
    always_comb begin
        w_sum_u   = {2'b00, r_int_active} + {{(SUM_W-Y_W){w_y_r[Y_W-1]}}, w_y_r};
        w_sum     = $signed(w_sum_u);
        w_sum_i   = 32'(w_sum);
        w_clamp   = (w_sum_i < int'(DIV_MIN)) || (w_sum_i > int'(DIV_MAX));
        w_capture = int_load_i && !r_ack;
    end

    // Integer word capture and single-cycle acknowledge, independent of en_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_active <= INT_W'(INT_RST);
            r_ack        <= 1'b0;
        end else begin
            r_ack <= w_capture;
            if (w_capture) begin
                r_int_active <= int_i;
            end
        end
    end

    // Second pipeline stage: clamped divide ratio with valid and saturation flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= INT_W'(INT_RST);
            r_vld <= 1'b0;
            r_sat <= 1'b0;
        end else if (en_i) begin
            r_div <= INT_W'(sat_clamp(w_sum_i, int'(DIV_MIN), int'(DIV_MAX)));
            r_vld <= 1'b1;
            r_sat <= w_clamp;
        end else begin
            r_vld <= 1'b0;
            r_sat <= 1'b0;
        end
    end

    // Sticky clamp flag; a capture in the same cycle wins over a new clamp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (w_capture) begin
            r_sticky <= 1'b0;
        end else if (en_i && w_clamp) begin
            r_sticky <= 1'b1;
        end
    end

`ifdef NCL_DITHER_EN
    logic [LFSR_W-1:0] r_lfsr;

    // Free-running dither LFSR, advancing with the modulator cascade.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (en_i) begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign dither_o = r_lfsr[0];
`else
    assign dither_o = 1'b0;
`endif

    assign int_ack_o    = r_ack;
    assign div_o        = r_div;
    assign div_vld_o    = r_vld;
    assign sat_o        = r_sat;
    assign sat_sticky_o = r_sticky;

endmodule

// File: tb/tb_mash111_ncl.sv
// Directed, table-driven bench for mash111_ncl (default parameters).
module tb_mash111_ncl;

    logic       clk;
    logic       rst_n;
    logic       en_i;
    logic       c1_i;
    logic       c2_i;
    logic       c3_i;
    logic [7:0] int_i;
    logic       int_load_i;
    logic       int_ack_o;
    logic [7:0] div_o;
    logic       div_vld_o;
    logic       sat_o;
    logic       sat_sticky_o;
    logic       dither_o;

    int n_checks;
    int n_errors;

    mash111_ncl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .c1_i         (c1_i),
        .c2_i         (c2_i),
        .c3_i         (c3_i),
        .int_i        (int_i),
        .int_load_i   (int_load_i),
        .int_ack_o    (int_ack_o),
        .div_o        (div_o),
        .div_vld_o    (div_vld_o),
        .sat_o        (sat_o),
        .sat_sticky_o (sat_sticky_o),
        .dither_o     (dither_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       ld;
        logic [7:0] din;
        logic [7:0] div;
        logic       vld;
        logic       sat;
        logic       sticky;
        logic       ack;
    } vec_t;

    vec_t vecs[32];

    function automatic vec_t mk(input logic en, input logic c1, input logic c2, input logic c3,
                                input logic ld, input logic [7:0] din, input logic [7:0] div,
                                input logic vld, input logic sat, input logic sticky, input logic ack);
        vec_t v;
        v.en = en; v.c1 = c1; v.c2 = c2; v.c3 = c3; v.ld = ld; v.din = din;
        v.div = div; v.vld = vld; v.sat = sat; v.sticky = sticky; v.ack = ack;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int div, input int vld, input int sat,
                           input int sticky, input int ack);
        chk({tag, ".div"},    int'(div_o),        div);
        chk({tag, ".vld"},    int'(div_vld_o),    vld);
        chk({tag, ".sat"},    int'(sat_o),        sat);
        chk({tag, ".sticky"}, int'(sat_sticky_o), sticky);
        chk({tag, ".ack"},    int'(int_ack_o),    ack);
    endtask

    logic [14:0] lfsr_m;
    logic        exp_dith;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; en_i = 1'b0; c1_i = 1'b0; c2_i = 1'b0; c3_i = 1'b0;
        int_i = 8'd0; int_load_i = 1'b0;

        //            en c1 c2 c3 ld din    div   vld sat stk ack
        vecs[0]  = mk(1, 0, 0, 0, 0, 8'd0,  8'd32, 1, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 8'd0,  8'd32, 1, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 1, 0, 8'd0,  8'd32, 1, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 0, 0, 8'd0,  8'd33, 1, 0, 0, 0);
        vecs[4]  = mk(1, 0, 0, 0, 0, 8'd0,  8'd30, 1, 0, 0, 0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 8'd0,  8'd33, 1, 0, 0, 0);
        vecs[6]  = mk(1, 0, 0, 0, 0, 8'd0,  8'd32, 1, 0, 0, 0);
        vecs[7]  = mk(1, 1, 1, 1, 0, 8'd0,  8'd32, 1, 0, 0, 0);
        vecs[8]  = mk(1, 1, 1, 1, 0, 8'd0,  8'd33, 1, 0, 0, 0);
        vecs[9]  = mk(1, 1, 1, 1, 0, 8'd0,  8'd32, 1, 0, 0, 0);
        vecs[10] = mk(1, 1, 1, 1, 0, 8'd0,  8'd33, 1, 0, 0, 0);
        vecs[11] = mk(1, 1, 1, 1, 0, 8'd0,  8'd33, 1, 0, 0, 0);
        vecs[12] = mk(1, 0, 0, 0, 0, 8'd0,  8'd33, 1, 0, 0, 0);
        vecs[13] = mk(1, 0, 0, 0, 0, 8'd0,  8'd32, 1, 0, 0, 0);
        vecs[14] = mk(1, 0, 0, 0, 0, 8'd0,  8'd33, 1, 0, 0, 0);
        vecs[15] = mk(1, 0, 0, 0, 0, 8'd0,  8'd32, 1, 0, 0, 0);
        // load 8, then a c3 pulse drives the ratio to 6 -> clamp at DIV_MIN
        vecs[16] = mk(1, 0, 0, 0, 1, 8'd8,  8'd32, 1, 0, 0, 1);
        vecs[17] = mk(1, 0, 0, 0, 0, 8'd0,  8'd8,  1, 0, 0, 0);
        vecs[18] = mk(1, 0, 0, 1, 0, 8'd0,  8'd8,  1, 0, 0, 0);
        vecs[19] = mk(1, 0, 0, 0, 0, 8'd0,  8'd9,  1, 0, 0, 0);
        vecs[20] = mk(1, 0, 0, 0, 0, 8'd0,  8'd8,  1, 1, 1, 0);
        vecs[21] = mk(1, 0, 0, 0, 0, 8'd0,  8'd9,  1, 0, 1, 0);
        vecs[22] = mk(1, 0, 0, 0, 0, 8'd0,  8'd8,  1, 0, 1, 0);
        // load 100 while frozen: ack pulses, sticky clears, div holds
        vecs[23] = mk(0, 0, 0, 0, 1, 8'd100, 8'd8,  0, 0, 0, 1);
        vecs[24] = mk(0, 0, 0, 0, 0, 8'd0,  8'd8,  0, 0, 0, 0);
        vecs[25] = mk(1, 0, 0, 0, 0, 8'd0,  8'd100, 1, 0, 0, 0);
        // load 255, c3 pulse drives 256 -> clamp at DIV_MAX; reload coincides with a clamp
        vecs[26] = mk(1, 0, 0, 0, 1, 8'd255, 8'd100, 1, 0, 0, 1);
        vecs[27] = mk(1, 0, 0, 1, 0, 8'd0,  8'd255, 1, 0, 0, 0);
        vecs[28] = mk(1, 0, 0, 0, 0, 8'd0,  8'd255, 1, 1, 1, 0);
        vecs[29] = mk(1, 0, 0, 0, 0, 8'd0,  8'd253, 1, 0, 1, 0);
        vecs[30] = mk(1, 0, 0, 0, 1, 8'd50, 8'd255, 1, 1, 0, 1);
        vecs[31] = mk(1, 0, 0, 0, 0, 8'd0,  8'd50,  1, 0, 0, 0);

        // reset state
        tick();
        tick();
        chk_all("reset", 32, 0, 0, 0, 0);
        rst_n = 1'b1;

        // table sweep
        for (int i = 0; i < 32; i++) begin
            en_i = vecs[i].en; c1_i = vecs[i].c1; c2_i = vecs[i].c2; c3_i = vecs[i].c3;
            int_load_i = vecs[i].ld; int_i = vecs[i].din;
            tick();
            chk_all($sformatf("vec%0d", i), int'(vecs[i].div), int'(vecs[i].vld),
                    int'(vecs[i].sat), int'(vecs[i].sticky), int'(vecs[i].ack));
        end

        // reset in the middle of a load request aborts it
        en_i = 1'b0; c1_i = 1'b0; c2_i = 1'b0; c3_i = 1'b0;
        int_i = 8'd77; int_load_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midload.div_rst", int'(div_o), 32);
        chk("midload.ack_rst", int'(int_ack_o), 0);
        int_load_i = 1'b0;
        tick();
        rst_n = 1'b1;
        en_i = 1'b1;
        tick();
        chk_all("midload.after", 32, 1, 0, 0, 0);

        // held request: capture, ack, then a second capture
        en_i = 1'b0;
        int_i = 8'd40; int_load_i = 1'b1;
        tick();
        chk("hold.ack1", int'(int_ack_o), 1);
        tick();
        chk("hold.ack2", int'(int_ack_o), 0);
        tick();
        chk("hold.ack3", int'(int_ack_o), 1);
        int_load_i = 1'b0;
        tick();
        chk("hold.ack4", int'(int_ack_o), 0);
        chk("hold.div_frozen", int'(div_o), 32);
        en_i = 1'b1;
        tick();
        chk("hold.div_new", int'(div_o), 40);

        // dither sequence right after reset
        en_i = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        en_i = 1'b1;
        lfsr_m = 15'h0001;
        for (int i = 0; i < 16; i++) begin
`ifdef NCL_DITHER_EN
            exp_dith = lfsr_m[0];
`else
            exp_dith = 1'b0;
`endif
            chk($sformatf("dither%0d", i), int'(dither_o), int'(exp_dith));
            lfsr_m = {lfsr_m[13:0], lfsr_m[14] ^ lfsr_m[13]};
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
